bin_to_bcd_converter: RTL

Sequential double-dabble converter that turns an unsigned binary value into eight packed BCD digits. It sits directly upstream of the seven-segment display controller. Its registered 32-bit `bcd_out` drives the controller's 32-bit display-value input, so any binary count, for example from switches or a counter, shows as decimal on the 8-digit display. Conversion is iterative, one bit per clock, with a start/busy/done handshake.

---
 rtl/bin_to_bcd_converter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_converter.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_converter
//
// Iterative double-dabble converter: turns an unsigned BIN_WIDTH-bit value into
// eight packed BCD digits, one input bit per clock. The registered result feeds
// the 8-digit seven-segment display controller directly, so it only changes
// once a conversion has finished.
//
// Handshake: a high `start` is accepted only while the FSM is idle. `busy`
// stays high from the accepting edge until the result edge. `done` is a
// one-cycle pulse in the cycle where `bcd_out` and `overflow` take their new
// values. A `start` seen while busy is dropped, not queued.
//
// Ports
//   clk        in   1          system clock, rising edge
//   reset      in   1          asynchronous, active-high reset
//   start      in   1          conversion request (sampled in IDLE only)
//   bin_in     in   BIN_WIDTH  unsigned binary value, captured on acceptance
//   busy       out  1          conversion in progress (SHIFT and DONE)
//   done       out  1          one-cycle pulse when the result updates
//   bcd_out    out  32         packed BCD, [3:0] = ones ... [31:28] = 10^7
//   overflow   out  1          captured value exceeded 99,999,999
//   dbg_state  out  2          current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module bin_to_bcd_converter #(
  parameter int BIN_WIDTH = 27
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          bcd_out,
  output logic                 overflow,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int              CW          = $clog2(BIN_WIDTH + 1);
  localparam logic [CW-1:0]   CNT_LAST    = CW'(BIN_WIDTH - 1);
  localparam logic [31:0]     BCD_MAX_BIN = 32'd99_999_999;
  localparam logic [31:0]     BCD_SAT     = 32'h9999_9999;

  state_t               state_q, state_d;
  logic [BIN_WIDTH-1:0] shift_bin_q, shift_bin_d;
  logic [31:0]          scratch_q, scratch_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [31:0]          bcd_q, bcd_d;
  logic                 overflow_q, overflow_d;
  logic [31:0]          adj;

  // Per-nibble "add 3 if >= 5"; nibbles are independent, no carry between them.
  function automatic logic [31:0] add3_nibbles(input logic [31:0] v);
    logic [31:0] r;
    r = v;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    shift_bin_d = shift_bin_q;
    scratch_d   = scratch_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    bcd_d       = bcd_q;
    overflow_d  = overflow_q;
    adj         = add3_nibbles(scratch_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          shift_bin_d = bin_in;
          scratch_d   = '0;
          cnt_d       = '0;
          ovf_d       = (32'(bin_in) > BCD_MAX_BIN);
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Adjust first, then shift the combined {scratch, shift_bin} left by one;
        // the bit leaving the top of scratch (digit carry) is discarded.
        {scratch_d, shift_bin_d} = {adj, shift_bin_q} << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        bcd_d      = ovf_q ? BCD_SAT : scratch_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // busy is registered from the next state so it rises on the accepting
    // edge and falls on the result edge.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_bin_q <= '0;
      scratch_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bcd_q       <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_bin_q <= shift_bin_d;
      scratch_q   <= scratch_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bcd_q       <= bcd_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bcd_out   = bcd_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule
